input_shift_register: RTL and testbench



---
 rtl/input_shift_register.sv | 168 ++++++++++++++++
 tb/tb_input_shift_register.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_shift_register.sv
// ----------------------------------------------------------------------------
// input_shift_register
//
// Per-state-machine input shift register (ISR) for the PIO core. Bits from the
// IN source selected upstream are accumulated here under fsm control, and
// completed words are handed to the RX fifo by autopush or an explicit PUSH.
// This block is the receive-side counterpart of output_shift_register.
//
// Ports:
//   clk             core clock
//   rst             asynchronous, active-high reset
//   data_in         IN source data; only the low n bits are used
//   shift_en        execute an IN of shift_count bits this cycle
//   shift_count     bits to shift, 1..DATA_WIDTH; 0 encodes DATA_WIDTH
//   shiftdir        1 = shift right (new bits at MSB), 0 = shift left (at LSB)
//   autopush_en     enable autopush
//   push_threshold  autopush threshold, 1..DATA_WIDTH; 0 encodes DATA_WIDTH
//   push_req        explicit PUSH instruction this cycle
//   push_block      PUSH stalls while the fifo is full
//   fifo_full       RX fifo full status
//   fifo_push_en    push strobe to the fifo (combinational)
//   fifo_data       word to the fifo; zero whenever fifo_push_en is low
//   isr             current ISR contents
//   isr_count       number of valid bits shifted in, saturating at DATA_WIDTH
//   stall           fsm must hold its pc while a push is pending
// ----------------------------------------------------------------------------
module input_shift_register #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          shift_en,
    input  logic [$clog2(DATA_WIDTH):0]   shift_count,
    input  logic                          shiftdir,
    input  logic                          autopush_en,
    input  logic [$clog2(DATA_WIDTH):0]   push_threshold,
    input  logic                          push_req,
    input  logic                          push_block,
    input  logic                          fifo_full,
    output logic                          fifo_push_en,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [DATA_WIDTH-1:0]         isr,
    output logic [$clog2(DATA_WIDTH):0]   isr_count,
    output logic                          stall
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] FULL_N = CW'(DATA_WIDTH);

    typedef enum logic {
        IDLE,
        PUSH_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] isr_q, isr_d;
    logic [CW-1:0]         count_q, count_d;

    logic [CW-1:0]         n, thr, nxt_count;
    logic [CW:0]           count_sum;
    logic [DATA_WIDTH-1:0] mask, nxt;
    logic                  autopush_hit;
    logic                  push_en;
    logic [DATA_WIDTH-1:0] push_data;

    // Zero in the count fields stands for a full word.
    assign n   = (shift_count    == '0) ? FULL_N : shift_count;
    assign thr = (push_threshold == '0) ? FULL_N : push_threshold;

    // Candidate next ISR value. The full-width case is split out so neither
    // direction ever shifts by the whole register width.
    always_comb begin
        mask = {DATA_WIDTH{1'b1}} >> (FULL_N - n);
        if (n == FULL_N) begin
            nxt = data_in;
        end else if (shiftdir) begin
            // Left-shifting data_in by (W-n) drops all but its low n bits.
            nxt = (isr_q >> n) | (data_in << (FULL_N - n));
        end else begin
            nxt = (isr_q << n) | (data_in & mask);
        end
    end

    // One extra bit on the sum so the saturation compare cannot wrap.
    assign count_sum    = {1'b0, count_q} + {1'b0, n};
    assign nxt_count    = (count_sum > {1'b0, FULL_N}) ? FULL_N : count_sum[CW-1:0];
    assign autopush_hit = autopush_en && (nxt_count >= thr);

    // NOTE: every signal driven here gets a default first so no path through
    // the case/if tree can leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        isr_d     = isr_q;
        count_d   = count_q;
        push_en   = 1'b0;
        push_data = '0;

        unique case (state_q)
            IDLE: begin
                if (shift_en) begin
                    // shift_en wins over push_req issued in the same cycle.
                    if (autopush_hit && !fifo_full) begin
                        push_en   = 1'b1;
                        push_data = nxt;
                        isr_d     = '0;
                        count_d   = '0;
                    end else begin
                        isr_d   = nxt;
                        count_d = nxt_count;
                        if (autopush_hit) begin
                            state_d = PUSH_WAIT;
                        end
                    end
                end else if (push_req) begin
                    if (!fifo_full) begin
                        push_en   = 1'b1;
                        push_data = isr_q;
                        isr_d     = '0;
                        count_d   = '0;
                    end else if (push_block) begin
                        state_d = PUSH_WAIT;
                    end else begin
                        // Non-blocking PUSH into a full fifo drops the word.
                        isr_d   = '0;
                        count_d = '0;
                    end
                end
            end

            PUSH_WAIT: begin
                // New IN/PUSH requests are ignored until the held word leaves.
                if (!fifo_full) begin
                    push_en   = 1'b1;
                    push_data = isr_q;
                    isr_d     = '0;
                    count_d   = '0;
                    state_d   = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of evaluation order between processes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            isr_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            isr_q   <= isr_d;
            count_q <= count_d;
        end
    end

    // The push strobe is combinational from inputs, so it is also masked by
    // rst to keep the fifo port quiet for the whole reset interval.
    assign fifo_push_en = push_en & ~rst;
    assign fifo_data    = (push_en && !rst) ? push_data : '0;
    assign isr          = isr_q;
    assign isr_count    = count_q;
    assign stall        = (state_q == PUSH_WAIT);

endmodule

// File: tb/tb_input_shift_register.sv
// ----------------------------------------------------------------------------
// tb_input_shift_register
//
// Self-checking bench for input_shift_register. A table of per-cycle records
// holds stimulus plus the expected pre-edge outputs (push strobe, stall) and
// post-edge register contents. Expected fifo words are queued when a vector
// that should push is driven and are popped when the DUT strobes
// fifo_push_en. Asynchronous reset during PUSH_WAIT is a hand-written
// sequence.
// ----------------------------------------------------------------------------
module tb_input_shift_register;

    logic        clk;
    logic        rst;
    logic [31:0] data_in;
    logic        shift_en;
    logic [5:0]  shift_count;
    logic        shiftdir;
    logic        autopush_en;
    logic [5:0]  push_threshold;
    logic        push_req;
    logic        push_block;
    logic        fifo_full;
    logic        fifo_push_en;
    logic [31:0] fifo_data;
    logic [31:0] isr;
    logic [5:0]  isr_count;
    logic        stall;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] sb[$];

    typedef struct {
        string       name;
        logic        se;
        logic [5:0]  sc;
        logic        dir;
        logic [31:0] din;
        logic        ape;
        logic [5:0]  thr;
        logic        preq;
        logic        pblk;
        logic        full;
        logic        exp_push;
        logic [31:0] exp_data;
        logic        exp_stall;
        logic [31:0] exp_isr;
        logic [5:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    input_shift_register #(.DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .shift_en       (shift_en),
        .shift_count    (shift_count),
        .shiftdir       (shiftdir),
        .autopush_en    (autopush_en),
        .push_threshold (push_threshold),
        .push_req       (push_req),
        .push_block     (push_block),
        .fifo_full      (fifo_full),
        .fifo_push_en   (fifo_push_en),
        .fifo_data      (fifo_data),
        .isr            (isr),
        .isr_count      (isr_count),
        .stall          (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic se, input logic [5:0] sc,
                                input logic dir, input logic [31:0] din, input logic ape,
                                input logic [5:0] thr, input logic preq, input logic pblk,
                                input logic full, input logic ep, input logic [31:0] ed,
                                input logic es, input logic [31:0] ei, input logic [5:0] ec);
        vec_t v;
        v.name = name; v.se = se; v.sc = sc; v.dir = dir; v.din = din; v.ape = ape;
        v.thr = thr; v.preq = preq; v.pblk = pblk; v.full = full; v.exp_push = ep;
        v.exp_data = ed; v.exp_stall = es; v.exp_isr = ei; v.exp_cnt = ec;
        return v;
    endfunction

    // Observe the fifo port before the edge; any strobe must match the oldest
    // queued expectation.
    task automatic observe_push(input string name, input logic exp_push);
        check({name, ".push_en"}, {31'b0, fifo_push_en}, {31'b0, exp_push});
        if (fifo_push_en) begin
            if (sb.size() == 0) begin
                check({name, ".unexpected_push"}, fifo_data, 32'hxxxx_xxxx);
            end else begin
                check({name, ".fifo_data"}, fifo_data, sb.pop_front());
            end
        end else begin
            check({name, ".fifo_data_idle"}, fifo_data, 32'h0);
        end
    endtask

    // Called just after a rising edge: drive, sample combinational outputs at
    // the falling edge, then check registered state after the next edge.
    task automatic apply(input vec_t v);
        shift_en       = v.se;
        shift_count    = v.sc;
        shiftdir       = v.dir;
        data_in        = v.din;
        autopush_en    = v.ape;
        push_threshold = v.thr;
        push_req       = v.preq;
        push_block     = v.pblk;
        fifo_full      = v.full;
        if (v.exp_push) sb.push_back(v.exp_data);
        @(negedge clk);
        check({v.name, ".stall"}, {31'b0, stall}, {31'b0, v.exp_stall});
        observe_push(v.name, v.exp_push);
        @(posedge clk);
        #1;
        check({v.name, ".isr"}, isr, v.exp_isr);
        check({v.name, ".isr_count"}, {26'b0, isr_count}, {26'b0, v.exp_cnt});
    endtask

    initial begin
        rst = 1'b1;
        data_in = '0; shift_en = 0; shift_count = '0; shiftdir = 0;
        autopush_en = 0; push_threshold = '0; push_req = 0; push_block = 0; fifo_full = 0;

        //            name        se sc  dir din           ape thr pr pb fu  ep ed            es isr           cnt
        // Left shift
        vecs.push_back(mk("l1",      1, 8,  0, 32'h0000_00AB, 0, 0, 0, 0, 0,  0, 0,             0, 32'h0000_00AB, 8));
        vecs.push_back(mk("l2",      1, 8,  0, 32'h0000_00CD, 0, 0, 0, 0, 0,  0, 0,             0, 32'h0000_ABCD, 16));
        vecs.push_back(mk("pushl",   0, 8,  0, 32'h0,         0, 0, 1, 0, 0,  1, 32'h0000_ABCD, 0, 32'h0,         0));
        // Right shift, then full-word shift with count saturation
        vecs.push_back(mk("r1",      1, 8,  1, 32'hFFFF_FF12, 0, 0, 0, 0, 0,  0, 0,             0, 32'h1200_0000, 8));
        vecs.push_back(mk("r32",     1, 0,  1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0,  0, 0,             0, 32'hDEAD_BEEF, 32));
        vecs.push_back(mk("pushr",   0, 8,  1, 32'h0,         0, 0, 1, 0, 0,  1, 32'hDEAD_BEEF, 0, 32'h0,         0));
        // Autopush at threshold 32
        vecs.push_back(mk("ap1",     1, 8,  0, 32'h11,        1, 0, 0, 0, 0,  0, 0,             0, 32'h0000_0011, 8));
        vecs.push_back(mk("ap2",     1, 8,  0, 32'h22,        1, 0, 0, 0, 0,  0, 0,             0, 32'h0000_1122, 16));
        vecs.push_back(mk("ap3",     1, 8,  0, 32'h33,        1, 0, 0, 0, 0,  0, 0,             0, 32'h0011_2233, 24));
        vecs.push_back(mk("ap4",     1, 8,  0, 32'h44,        1, 0, 0, 0, 0,  1, 32'h1122_3344, 0, 32'h0,         0));
        // Autopush with fifo full: stall, ignore shifts, release
        vecs.push_back(mk("af1",     1, 8,  0, 32'h11,        1, 0, 0, 0, 1,  0, 0,             0, 32'h0000_0011, 8));
        vecs.push_back(mk("af2",     1, 8,  0, 32'h22,        1, 0, 0, 0, 1,  0, 0,             0, 32'h0000_1122, 16));
        vecs.push_back(mk("af3",     1, 8,  0, 32'h33,        1, 0, 0, 0, 1,  0, 0,             0, 32'h0011_2233, 24));
        vecs.push_back(mk("af4",     1, 8,  0, 32'h44,        1, 0, 0, 0, 1,  0, 0,             0, 32'h1122_3344, 32));
        vecs.push_back(mk("afw1",    1, 8,  0, 32'h55,        1, 0, 1, 1, 1,  0, 0,             1, 32'h1122_3344, 32));
        vecs.push_back(mk("afw2",    1, 8,  0, 32'h55,        1, 0, 0, 0, 1,  0, 0,             1, 32'h1122_3344, 32));
        vecs.push_back(mk("afw3",    1, 8,  0, 32'h55,        1, 0, 0, 0, 1,  0, 0,             1, 32'h1122_3344, 32));
        vecs.push_back(mk("afrel",   1, 8,  0, 32'h55,        1, 0, 0, 0, 0,  1, 32'h1122_3344, 1, 32'h0,         0));
        vecs.push_back(mk("afidle",  0, 8,  0, 32'h0,         0, 0, 0, 0, 0,  0, 0,             0, 32'h0,         0));
        // Explicit PUSH into full fifo: non-blocking drops, blocking stalls
        vecs.push_back(mk("p5a",     1, 8,  0, 32'h5A,        0, 0, 0, 0, 0,  0, 0,             0, 32'h0000_005A, 8));
        vecs.push_back(mk("pdrop",   0, 8,  0, 32'h0,         0, 0, 1, 0, 1,  0, 0,             0, 32'h0,         0));
        vecs.push_back(mk("p5b",     1, 8,  0, 32'h5A,        0, 0, 0, 0, 0,  0, 0,             0, 32'h0000_005A, 8));
        vecs.push_back(mk("pblk",    0, 8,  0, 32'h0,         0, 0, 1, 1, 1,  0, 0,             0, 32'h0000_005A, 8));
        vecs.push_back(mk("pw1",     0, 8,  0, 32'h0,         0, 0, 1, 1, 1,  0, 0,             1, 32'h0000_005A, 8));
        vecs.push_back(mk("pw2",     0, 8,  0, 32'h0,         0, 0, 0, 1, 1,  0, 0,             1, 32'h0000_005A, 8));
        vecs.push_back(mk("prel",    0, 8,  0, 32'h0,         0, 0, 0, 1, 0,  1, 32'h0000_005A, 1, 32'h0,         0));
        vecs.push_back(mk("pidle",   0, 8,  0, 32'h0,         0, 0, 0, 0, 0,  0, 0,             0, 32'h0,         0));
        // shift_en beats push_req; threshold below 32; push of an empty ISR
        vecs.push_back(mk("prio",    1, 8,  0, 32'h01,        0, 0, 1, 0, 0,  0, 0,             0, 32'h0000_0001, 8));
        vecs.push_back(mk("thr12",   1, 8,  0, 32'h02,        1, 12, 0, 0, 0, 1, 32'h0000_0102, 0, 32'h0,         0));
        vecs.push_back(mk("pempty",  0, 8,  0, 32'h0,         0, 0, 1, 0, 0,  1, 32'h0,         0, 32'h0,         0));
        // Right shift of 4 bits after 28 valid bits reaches the 32 threshold
        vecs.push_back(mk("r28",     1, 28, 1, 32'h0ABC_DEF1, 1, 0, 0, 0, 0,  0, 0,             0, 32'hABCD_EF10, 28));
        vecs.push_back(mk("r4ap",    1, 4,  1, 32'h0000_0009, 1, 0, 0, 0, 0,  1, 32'h9ABC_DEF1, 0, 32'h0,         0));

        repeat (2) @(posedge clk);
        #1;
        check("reset.isr", isr, 32'h0);
        check("reset.isr_count", {26'b0, isr_count}, 32'h0);
        check("reset.stall", {31'b0, stall}, 32'h0);
        check("reset.push_en", {31'b0, fifo_push_en}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Asynchronous reset while a blocked PUSH is pending.
        apply(mk("rs_load",  1, 8, 0, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0077, 8));
        apply(mk("rs_block", 0, 8, 0, 32'h0,  0, 0, 1, 1, 1, 0, 0, 0, 32'h0000_0077, 8));
        shift_en = 0; push_req = 0;
        check("rs_wait.stall", {31'b0, stall}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("rs_async.stall", {31'b0, stall}, 32'h0);
        check("rs_async.isr", isr, 32'h0);
        check("rs_async.isr_count", {26'b0, isr_count}, 32'h0);
        check("rs_async.push_en", {31'b0, fifo_push_en}, 32'h0);
        fifo_full = 1'b0;
        #1;
        check("rs_held.push_en", {31'b0, fifo_push_en}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(mk("rs_after1", 0, 8, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
        apply(mk("rs_after2", 0, 8, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));

        check("scoreboard_empty", sb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
